// File: rtl/image_unpacker_pkg.sv
// image_unpacker_pkg: shared image width default, word width, header magic and FSM encoding
// Defines `DEPTH (image width in bits) when the build does not provide it.
`ifndef DEPTH
`define DEPTH 96
`endif
package image_unpacker_pkg;
  localparam int DEPTH_DEFAULT = `DEPTH;
  localparam int WORD_BITS = 32;
  localparam logic [15:0] HDR_MAGIC = 16'hA5A5;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
endpackage

// File: rtl/word_shift_reg.sv
// word_shift_reg: parallel-load register that shifts left one word per advance
// Ports: clk, rst (sync, active high); load/data parallel load; advance shifts
// left by 32; top exposes the most significant 32 bits.
module word_shift_reg
  import image_unpacker_pkg::*;
#(
  parameter int W = 96
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         advance,
  output logic [31:0]  top
);
  logic [W-1:0] r;
  always_ff @(posedge clk)
    r <= rst ? '0 : load ? data : advance ? r << WORD_BITS : r;
  assign top = r[W-1 -: WORD_BITS];
endmodule

// File: rtl/image_unpacker.sv
// image_unpacker: accepts a whole DEPTH-bit image and streams it MSB word first as 32-bit words
// Ports: clk, rst (sync, active high); frame_valid/frame_ready/frame_in accept
// a complete image; word_out/word_valid/word_ready/word_last form the output
// stream. Defining IMAGE_UNPACKER_HEADER_EN prepends {16'hA5A5, seq} to each
// frame, with seq counting completed frames since reset.
module image_unpacker
  import image_unpacker_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int WORD_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_valid,
  input  logic [DEPTH-1:0] frame_in,
  output logic             frame_ready,
  output logic [31:0]      word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             word_last
);
  localparam int NUM_WORDS = (DEPTH + WORD_BITS - 1) / WORD_BITS;
`ifdef IMAGE_UNPACKER_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int TOTAL = NUM_WORDS + HDR;
  localparam int SR_W = TOTAL * WORD_BITS;
  localparam int IW = $clog2(NUM_WORDS + 1);
  if (WORD_W != 32) begin : g_bad_word_w
    $error("image_unpacker: WORD_W must be 32");
  end
  if (DEPTH < 32) begin : g_bad_depth
    $error("image_unpacker: DEPTH must be at least 32");
  end
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [SR_W-1:0] load_data;
  logic accept, take, last;
  assign accept = frame_valid && state == IDLE;
  assign take = word_valid && word_ready;
  assign last = state == SEND && idx == IW'(TOTAL - 1);
`ifdef IMAGE_UNPACKER_HEADER_EN
  logic [15:0] seq;
  always_ff @(posedge clk)
    seq <= rst ? '0 : seq + 16'(take && last);
  always_comb begin
    load_data = '0;
    load_data[SR_W-1 -: WORD_BITS] = {HDR_MAGIC, seq};
    load_data[SR_W-1-WORD_BITS -: DEPTH] = frame_in;
  end
`else
  // Image sits at the top of the register; the low-order pad stays zero.
  always_comb begin
    load_data = '0;
    load_data[SR_W-1 -: DEPTH] = frame_in;
  end
`endif
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb
    state_n = accept ? SEND : (take && last) ? IDLE : state;
  always_ff @(posedge clk)
    idx <= (rst || accept || (take && last)) ? '0 : take ? idx + 1'b1 : idx;
  word_shift_reg #(.W(SR_W)) u_sr (
    .clk(clk),
    .rst(rst),
    .load(accept),
    .data(load_data),
    .advance(take),
    .top(word_out)
  );
  assign frame_ready = state == IDLE;
  assign word_valid = state == SEND;
  assign word_last = last;
endmodule

// File: tb/tb_image_unpacker.sv
// tb_image_unpacker: drives a 96-bit and a 40-bit unpacker against a word-list model of each frame
module tb_image_unpacker;
  localparam int DA = 96, DB = 40;
`ifdef IMAGE_UNPACKER_HEADER_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif
  logic clk = 0, rst = 1, mon_on = 0;
  logic fv_a = 0, fv_b = 0, rdy_a = 0, rdy_b = 0;
  logic [DA-1:0] fa = '0;
  logic [DB-1:0] fb = '0;
  logic fr_a, fr_b, wv_a, wv_b, wl_a, wl_b;
  logic [31:0] wo_a, wo_b;
  int errors = 0, checks = 0;
  logic [31:0] q [3][$];
  logic [15:0] seq [2];
  always #5 clk = ~clk;

  image_unpacker #(.DEPTH(DA), .WORD_W(32)) u_a (
    .clk(clk), .rst(rst), .frame_valid(fv_a), .frame_in(fa), .frame_ready(fr_a),
    .word_out(wo_a), .word_valid(wv_a), .word_ready(rdy_a), .word_last(wl_a));
  image_unpacker #(.DEPTH(DB), .WORD_W(32)) u_b (
    .clk(clk), .rst(rst), .frame_valid(fv_b), .frame_in(fb), .frame_ready(fr_b),
    .word_out(wo_b), .word_valid(wv_b), .word_ready(rdy_b), .word_last(wl_b));

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Word k, bit j carries image bit (d-1-32k-(31-j)); positions below bit 0 read as zero.
  function automatic void expand(int u, logic [255:0] f, int d, logic [15:0] s);
    int nw = (d + 31) / 32;
    logic [31:0] w;
    if (H == 1) q[u].push_back({16'hA5A5, s});
    for (int k = 0; k < nw; k++) begin
      for (int j = 0; j < 32; j++) begin
        int b = d - 1 - 32 * k - (31 - j);
        w[j] = (b >= 0) ? f[b] : 1'b0;
      end
      q[u].push_back(w);
    end
  endfunction

  always @(negedge clk) if (mon_on) begin
    logic v, r, l, fv, rd, idle;
    logic [31:0] w;
    logic [255:0] f;
    for (int u = 0; u < 2; u++) begin
      v = u == 1 ? wv_b : wv_a;
      r = u == 1 ? fr_b : fr_a;
      l = u == 1 ? wl_b : wl_a;
      w = u == 1 ? wo_b : wo_a;
      fv = u == 1 ? fv_b : fv_a;
      rd = u == 1 ? rdy_b : rdy_a;
      f = u == 1 ? 256'(fb) : 256'(fa);
      idle = q[u].size() == 0;
      chk($sformatf("frame_ready[u%0d]", u), 32'(r), 32'(idle));
      chk($sformatf("word_valid[u%0d]", u), 32'(v), 32'(!idle));
      if (!idle) begin
        chk($sformatf("word_out[u%0d]", u), w, q[u][0]);
        chk($sformatf("word_last[u%0d]", u), 32'(l), 32'(q[u].size() == 1));
      end
      if (rst) begin
        q[u].delete();
        seq[u] = '0;
      end else if (idle) begin
        if (fv) expand(u, f, u == 1 ? DB : DA, seq[u]);
      end else if (rd) begin
        void'(q[u].pop_front());
        if (q[u].size() == 0) seq[u]++;
      end
    end
  end

  initial begin
    logic [31:0] ea [3];
    logic [31:0] eb [2];
    logic [5:0] pat;
    int n;
    ea = '{32'h11111111, 32'h22222222, 32'h33333333};
    eb = '{32'hABCDEF01, 32'h23000000};
    pat = 6'b101001;
    seq[0] = '0;
    seq[1] = '0;
    expand(2, 256'(96'h1111_1111_2222_2222_3333_3333), 96, 16'd7);
    chk("model_w0_96", q[2][H], 32'h11111111);
    chk("model_w2_96", q[2][H+2], 32'h33333333);
    q[2].delete();
    expand(2, 256'(40'hAB_CDEF_0123), 40, 16'd7);
    chk("model_pad_40", q[2][H+1], 32'h23000000);
    chk("model_len_40", q[2].size(), H + 2);
    @(posedge clk); #1;
    mon_on = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_word_out", wo_a, 32'h0);
    chk("rst_word_last", 32'(wl_a), 32'h0);
    chk("rst_word_valid", 32'(wv_a), 32'h0);
    chk("rst_frame_ready", 32'(fr_a), 32'h1);
    // basic frame on both units with word_ready held high
    @(posedge clk); #1;
    fv_a = 1; fa = 96'h1111_1111_2222_2222_3333_3333; rdy_a = 1;
    fv_b = 1; fb = 40'hAB_CDEF_0123; rdy_b = 1;
    @(posedge clk); #1;
    fv_a = 0; fv_b = 0;
    for (int k = 0; k < H + 3; k++) begin
      @(negedge clk);
      chk("basic_word", wo_a, k < H ? 32'hA5A50000 : ea[k-H]);
      chk("basic_last", 32'(wl_a), 32'(k == H + 2));
      if (k < H + 2) begin
        chk("pad_word", wo_b, k < H ? 32'hA5A50000 : eb[k-H]);
        chk("pad_last", 32'(wl_b), 32'(k == H + 1));
      end
    end
    @(negedge clk);
    chk("basic_ready_back", 32'(fr_a), 32'h1);
    // backpressure on unit a; unit b holds a different frame_valid image while busy
    @(posedge clk); #1;
    fv_a = 1; fb = 40'h11_2233_4455; fv_b = 1;
    @(posedge clk); #1;
    fv_a = 0; fb = 40'h99_AABB_CCDD;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      rdy_a = i < 6 ? pat[i] : 1'b1;
      @(negedge clk);
      if (i == 0) chk("bp_first", wo_a, H == 1 ? 32'hA5A50001 : 32'h11111111);
      if (wv_a && rdy_a) n++;
      @(posedge clk); #1;
    end
    fv_b = 0;
    chk("bp_handshakes", n, H + 3);
    repeat (6) @(posedge clk);
    #1;
    // reset in the middle of a frame, then a fresh frame starts from word 0
    fv_a = 1; fa = {$urandom(), $urandom(), $urandom()};
    @(posedge clk); #1;
    fv_a = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_mid_valid", 32'(wv_a), 32'h0);
    chk("rst_mid_ready", 32'(fr_a), 32'h1);
    @(posedge clk); #1;
    fv_a = 1; fa = 96'hDEAD_BEEF_0000_1111_2222_3333;
    @(posedge clk); #1;
    fv_a = 0;
    @(negedge clk);
    chk("restart_word0", wo_a, H == 1 ? 32'hA5A50000 : 32'hDEADBEEF);
    // randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      fv_a = $urandom_range(0, 3) != 0;
      fv_b = $urandom_range(0, 3) != 0;
      fa = {$urandom(), $urandom(), $urandom()};
      fb = 40'({$urandom(), $urandom()});
      rdy_a = $urandom_range(0, 3) != 0;
      rdy_b = $urandom_range(0, 1) != 0;
      rst = $urandom_range(0, 299) == 0;
    end
    @(posedge clk); #1;
    rst = 0; fv_a = 0; fv_b = 0;
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/image_unpacker.md
# image_unpacker

Transmit-side counterpart of the AXI image collector: accepts one complete `DEPTH`-bit lattice image in a single cycle and streams it out as 32-bit words on a valid/ready interface towards the AXI write path. It sits between the collision/streaming core's image output and the AXI master. Its word order matches the collector's, so a frame sent by this block and captured by the collector reproduces the original image bit-for-bit.

## Interface
- `DEPTH`, default `` `DEPTH `` from `def.vh`: image width in bits; any value ≥ 32.
- `WORD_W`, default 32: output word width; fixed at 32, and elaboration fails for any other value.
- `NUM_WORDS`, derived: ceil(`DEPTH`/32), the number of payload words per frame.
- `clk`  in  1  single clock for the block; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `frame_valid`  in  1  `frame_in` holds a complete image.
- `frame_in`  in  `DEPTH`  the image; sampled only on the accept cycle.
- `frame_ready`  out  1  block is idle and can accept a frame.
- `word_out`  out  32  current output word.
- `word_valid`  out  1  `word_out` is valid.
- `word_ready`  in  1  AXI side takes `word_out` this cycle.
- `word_last`  out  1  `word_out` is the final word of the frame.

## Operation
- The block has two states, IDLE and SEND. Reset state is IDLE.
- **IDLE:** `frame_ready`=1 and `word_valid`=0. When `frame_valid && frame_ready` is true, the accept happens:
  - `frame_in` is latched into a shift register, zero-padded in the LSBs to `NUM_WORDS`×32 bits.
  - The word index is cleared to 0.
  - The state moves to SEND.
- **SEND:** `frame_ready`=0 and `word_valid`=1. `word_out` is the top 32 bits of the shift register.
  - Word k is `frame[DEPTH-1-32k -: 32]`, so the MSB word goes first. In the last word, any bits below bit 0 are padded with 0.
  - On each `word_valid && word_ready` handshake, the register shifts left by 32 and the index increments.
  - `word_last` = (index == total words − 1).
  - A handshake while `word_last` is high returns the block to IDLE.
- **AXI-stream rules:**
  - Once `word_valid` is asserted, `word_out` and `word_last` must not change until the handshake completes.
  - `word_valid` must not depend combinationally on `word_ready`.
  - `word_ready` may toggle arbitrarily; stall cycles add latency only.
- **Input rules:**
  - `frame_valid` while `frame_ready`=0 is ignored. The source holds it until accepted.
  - `frame_in` may change freely after the accept cycle.
- **Reset mid-frame:** the frame is discarded. The next cycle shows IDLE, `word_valid`=0, and index=0. The header sequence counter is also cleared.
- The index counter is sized as clog2(`NUM_WORDS`+1) bits and never wraps within a frame.

## Timing
- All outputs are registered.
- Reset values: `frame_ready`=1, `word_valid`=0, `word_last`=0, `word_out`=0.
- **Latency:** accept in cycle T gives the first word valid in cycle T+1.
- **Throughput:** with `word_ready` held high, one word per cycle. The final handshake in cycle T+N is followed by IDLE in cycle T+N+1, so the minimum frame period is N+1 cycles, where N is the total word count.
- A single-word frame (`DEPTH`≤32) has `word_last`=1 on its only word.

## Configuration
- **`IMAGE_UNPACKER_HEADER_EN` defined:**
  - Each frame starts with a header word `{16'hA5A5, seq[15:0]}` before payload word 0.
  - `seq` starts at 0 after reset, increments by 1 after each completed frame, and wraps from 16'hFFFF to 0.
  - Total words = `NUM_WORDS`+1.
- **Undefined:** there is no header and no sequence counter. Total words = `NUM_WORDS`.

## Structure
- Shared package / `def.vh` holds:
  - the `DEPTH` define;
  - the word width constant (32);
  - the header magic 16'hA5A5;
  - the state encoding (IDLE=0, SEND=1).
- There is one natural sub-module, `word_shift_reg`: a parallel-load register that shifts left by 32 on an advance input and exposes its top 32 bits. It is shared in concept with the collector. The FSM, index and sequence counter stay in the top level.

## Test plan
- **Basic frame:** `DEPTH`=96, `word_ready`=1, `frame_in`=96'h1111_1111_2222_2222_3333_3333, accepted at T.
  - Expect 32'h11111111, 32'h22222222, 32'h33333333 at T+1..T+3.
  - `word_last` is high only at T+3, and `frame_ready` returns high at T+4.
- **Backpressure:** same frame with `word_ready` toggling 1,0,0,1,0,1.
  - `word_out` and `word_last` stay stable through the stall cycles.
  - Exactly 3 handshakes occur, in the same order.
- **Padding:** `DEPTH`=40, `frame_in`=40'hAB_CDEF_0123.
  - Expect words 32'hABCDEF01, then 32'h23000000 with `word_last`=1.
- **Input gating and reset:**
  - `frame_valid` held high during SEND with a different `frame_in` → ignored; the current frame completes unchanged.
  - `rst` pulsed after word 1 → next cycle shows `word_valid`=0 and `frame_ready`=1; a new frame then starts from word 0.
- **Header build, `IMAGE_UNPACKER_HEADER_EN` defined:** two back-to-back frames.
  - First words are 32'hA5A50000, then 32'hA5A50001; each frame has `NUM_WORDS`+1 words.
  - After a reset, the next header is 32'hA5A50000 again.
- **Loopback:** connect to the collector (matching `DEPTH`) and send 100 random frames → each captured image equals the frame that was sent.
